// File: rtl/time_cmd_parser.sv
// Parses "@HH:MM:SS<CR|LF>" frames from a first-word-fall-through RX FIFO and
// publishes the BCD time on a valid terminator; malformed or stalled frames pulse oErr.
module time_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRx_Empty,
    input  logic [7:0] iRx_Data,
    output logic       oRx_Pop,
    output logic [3:0] oDigit_Hour_10,
    output logic [3:0] oDigit_Hour_1,
    output logic [3:0] oDigit_Min_10,
    output logic [3:0] oDigit_Min_1,
    output logic [3:0] oDigit_Sec_10,
    output logic [3:0] oDigit_Sec_1,
    output logic       oLoad,
    output logic       oErr,
    output logic       oBusy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The counter reaches TIMEOUT_CYCLES-1 on the edge that ends the firing cycle.
    localparam logic [CW-1:0] FIRE_CNT = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        HR10  = 4'd1,
        HR1   = 4'd2,
        COL1  = 4'd3,
        MIN10 = 4'd4,
        MIN1  = 4'd5,
        COL2  = 4'd6,
        SEC10 = 4'd7,
        SEC1  = 4'd8,
        TERM  = 4'd9,
        LOAD  = 4'd10
    } state_t;

    state_t          state_q, state_d, adv_s;
    logic            pop_hist_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      sh_q  [6];
    logic [3:0]      dig_q [6];
    logic            load_q, err_q, busy_q, err_d;
    logic [5:0]      cap_we_s, sh_we_s;
    logic            counting_s, tmo_fire_s, pop_s, byte_ok_s;
    logic            is_digit_s, is_at_s, is_col_s, is_term_s;
    logic [3:0]      digit_s;

    assign counting_s = (state_q != IDLE) && (state_q != LOAD);
    assign tmo_fire_s = counting_s && (cnt_q == FIRE_CNT);
    assign pop_s      = iRst && !iRx_Empty && !pop_hist_q && !tmo_fire_s;

    assign is_digit_s = (iRx_Data >= 8'h30) && (iRx_Data <= 8'h39);
    assign digit_s    = iRx_Data[3:0];
    assign is_at_s    = (iRx_Data == 8'h40);
    assign is_col_s   = (iRx_Data == 8'h3A);
    assign is_term_s  = (iRx_Data == 8'h0D) || (iRx_Data == 8'h0A);

    // Per-state byte legality, successor state and shadow capture slot.
    always_comb begin
        byte_ok_s = 1'b0;
        adv_s     = IDLE;
        cap_we_s  = 6'b000000;
        case (state_q)
            HR10:  begin byte_ok_s = is_digit_s && (digit_s <= 4'd2); adv_s = HR1;   cap_we_s = 6'b000001; end
            HR1:   begin
                byte_ok_s = is_digit_s && ((sh_q[0] == 4'd2) ? (digit_s <= 4'd3) : 1'b1);
                adv_s     = COL1;
                cap_we_s  = 6'b000010;
            end
            COL1:  begin byte_ok_s = is_col_s;                          adv_s = MIN10; end
            MIN10: begin byte_ok_s = is_digit_s && (digit_s <= 4'd5); adv_s = MIN1;  cap_we_s = 6'b000100; end
            MIN1:  begin byte_ok_s = is_digit_s;                        adv_s = COL2;  cap_we_s = 6'b001000; end
            COL2:  begin byte_ok_s = is_col_s;                          adv_s = SEC10; end
            SEC10: begin byte_ok_s = is_digit_s && (digit_s <= 4'd5); adv_s = SEC1;  cap_we_s = 6'b010000; end
            SEC1:  begin byte_ok_s = is_digit_s;                        adv_s = TERM;  cap_we_s = 6'b100000; end
            TERM:  begin byte_ok_s = is_term_s;                         adv_s = LOAD;  end
            default: begin byte_ok_s = 1'b0; adv_s = IDLE; cap_we_s = 6'b000000; end
        endcase
    end

    // Next-state: timeout beats a byte; a bad '@' restarts the frame instead of dropping it.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        sh_we_s = 6'b000000;
        case (state_q)
            IDLE: begin
                if (pop_s && is_at_s) state_d = HR10;
                else                  state_d = IDLE;
            end
            LOAD: state_d = IDLE;
            default: begin
                if (tmo_fire_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (pop_s && byte_ok_s) begin
                    state_d = adv_s;
                    sh_we_s = cap_we_s;
                end else if (pop_s) begin
                    state_d = is_at_s ? HR10 : IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // Inter-byte timeout counter, saturating at terminal count.
    always_comb begin
        if (pop_s || !counting_s)   cnt_d = '0;
        else if (cnt_q != TERM_CNT) cnt_d = cnt_q + CNT_ONE;
        else                        cnt_d = cnt_q;
    end

    // State, shadows, published digits and status pulses.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q    <= IDLE;
            pop_hist_q <= 1'b0;
            cnt_q      <= '0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                sh_q[i]  <= 4'd0;
                dig_q[i] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            pop_hist_q <= pop_s;
            cnt_q      <= cnt_d;
            load_q     <= (state_d == LOAD);
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
            for (int i = 0; i < 6; i++) begin
                if (sh_we_s[i])        sh_q[i]  <= digit_s;
                if (state_d == LOAD)   dig_q[i] <= sh_q[i];
            end
        end
    end

    assign oRx_Pop        = pop_s;
    assign oLoad          = load_q;
    assign oErr           = err_q;
    assign oBusy          = busy_q;
    assign oDigit_Hour_10 = dig_q[0];
    assign oDigit_Hour_1  = dig_q[1];
    assign oDigit_Min_10  = dig_q[2];
    assign oDigit_Min_1   = dig_q[3];
    assign oDigit_Sec_10  = dig_q[4];
    assign oDigit_Sec_1   = dig_q[5];

endmodule

// File: tb/tb_time_cmd_parser.sv
// Bench for time_cmd_parser: FIFO model feeding directed and random frames, a
// frame-level reference model compared every cycle, plus literal spot checks.
module tb_time_cmd_parser;

    localparam int TMO = 16;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iRx_Empty = 1'b1;
    logic [7:0] iRx_Data = 8'h00;
    logic       oRx_Pop, oLoad, oErr, oBusy;
    logic [3:0] oDigit_Hour_10, oDigit_Hour_1, oDigit_Min_10, oDigit_Min_1, oDigit_Sec_10, oDigit_Sec_1;
    logic [23:0] dut_digits;

    time_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .iClk(iClk), .iRst(iRst), .iRx_Empty(iRx_Empty), .iRx_Data(iRx_Data), .oRx_Pop(oRx_Pop),
        .oDigit_Hour_10(oDigit_Hour_10), .oDigit_Hour_1(oDigit_Hour_1),
        .oDigit_Min_10(oDigit_Min_10), .oDigit_Min_1(oDigit_Min_1),
        .oDigit_Sec_10(oDigit_Sec_10), .oDigit_Sec_1(oDigit_Sec_1),
        .oLoad(oLoad), .oErr(oErr), .oBusy(oBusy)
    );

    assign dut_digits = {oDigit_Hour_10, oDigit_Hour_1, oDigit_Min_10, oDigit_Min_1, oDigit_Sec_10, oDigit_Sec_1};

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Frame rule for the byte at position pos (1..9) after '@'.
    function automatic bit byte_ok(input int pos, input logic [7:0] b, input logic [3:0] h10);
        int lim;
        if (pos == 3 || pos == 6) return (b == 8'h3A);
        if (pos == 9) return (b == 8'h0D || b == 8'h0A);
        if (b < 8'h30 || b > 8'h39) return 1'b0;
        if (pos == 1)                  lim = 2;
        else if (pos == 4 || pos == 7) lim = 5;
        else if (pos == 2 && h10 == 4'd2) lim = 3;
        else                           lim = 9;
        return (int'(b) - 'h30) <= lim;
    endfunction

    // Reference model: m_pos = bytes of the current frame consumed (0 hunting, 10 loading).
    int          cyc = 0;
    int          m_pos = 0;
    int          m_last = 0;
    logic [3:0]  m_sh [6];
    logic [3:0]  m_dig [6];
    bit          m_hist = 0, e_load = 0, e_err = 0, e_busy = 0;
    int          n_err = 0, n_load = 0, last_pop_cyc = 0, last_err_cyc = 0, last_load_cyc = 0;
    int          popped_byte [int];
    bit          pop_n = 0;

    always @(negedge iClk) begin : cmp
        bit fire, e_pop;
        if (!iRst) begin
            m_pos = 0; m_hist = 0; e_load = 0; e_err = 0; e_busy = 0;
            for (int i = 0; i < 6; i++) begin m_sh[i] = 4'd0; m_dig[i] = 4'd0; end
        end
        fire  = iRst && (m_pos >= 1) && (m_pos <= 9) && (cyc - m_last == TMO - 1);
        e_pop = iRst && !iRx_Empty && !m_hist && !fire;
        chk("pop", int'(oRx_Pop), int'(e_pop));
        chk("load", int'(oLoad), int'(e_load));
        chk("err", int'(oErr), int'(e_err));
        chk("busy", int'(oBusy), int'(e_busy));
        chk("digits", int'(dut_digits), int'({m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dig[4], m_dig[5]}));
        pop_n = oRx_Pop;
        if (oRx_Pop) begin last_pop_cyc = cyc; popped_byte[cyc] = int'(iRx_Data); end
        if (oErr)  begin n_err++;  last_err_cyc = cyc; end
        if (oLoad) begin n_load++; last_load_cyc = cyc; end
        if (iRst) begin
            e_load = 0;
            e_err  = 0;
            if (m_pos == 10) m_pos = 0;
            else if (fire) begin m_pos = 0; e_err = 1; end
            else if (e_pop) begin
                m_last = cyc;
                if (m_pos == 0) begin
                    if (iRx_Data == 8'h40) m_pos = 1;
                end else if (byte_ok(m_pos, iRx_Data, m_sh[0])) begin
                    if (m_pos % 3 != 0) m_sh[(m_pos - 1) - (m_pos - 1) / 3] = iRx_Data[3:0];
                    m_pos++;
                    if (m_pos == 10) begin m_dig = m_sh; e_load = 1; end
                end else begin
                    e_err = 1;
                    m_pos = (iRx_Data == 8'h40) ? 1 : 0;
                end
            end
            m_hist = e_pop;
            e_busy = (m_pos != 0);
        end
        cyc++;
    end

    logic [7:0] fifo [$];

    task automatic drive();
        iRx_Empty = (fifo.size() == 0);
        iRx_Data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
        if (pop_n && fifo.size() != 0) fifo.delete(0);
        drive();
    endtask

    task automatic push(input string s, input int gap_max);
        for (int i = 0; i < s.len(); i++) begin
            fifo.push_back(s[i]);
            drive();
            if (gap_max > 0) repeat ($urandom_range(gap_max, 1)) step();
        end
    endtask

    task automatic drain(input string name);
        bit done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            step();
            if (fifo.size() == 0 && !oBusy && !pop_n) done = 1;
        end
        repeat (3) step();
        chk({name, "_drain"}, int'(done), 1);
    endtask

    int e0, l0;

    initial begin : main
        repeat (3) step();
        chk("reset_digits", int'(dut_digits), 0);
        chk("reset_busy", int'(oBusy), 0);
        @(posedge iClk); #1 iRst = 1'b1;
        repeat (2) step();

        push("@12:34:56\r", 2);
        drain("valid");
        chk("valid_loads", n_load, 1);
        chk("valid_errs", n_err, 0);
        chk("valid_digits", int'(dut_digits), 'h123456);
        chk("valid_load_latency", last_load_cyc - last_pop_cyc, 1);

        push("@24:00:00\n", 1);
        drain("range1");
        chk("range1_errs", n_err, 1);
        chk("range1_err_byte", popped_byte[last_err_cyc - 1], 'h34);
        chk("range1_digits", int'(dut_digits), 'h123456);
        push("@23:60:00\n", 1);
        drain("range2");
        chk("range2_errs", n_err, 2);
        chk("range2_err_byte", popped_byte[last_err_cyc - 1], 'h36);
        chk("range_loads", n_load, 1);

        push("xyz", 1);
        drain("garbage");
        chk("garbage_errs", n_err, 2);
        push("@12:3@23:59:59\n", 1);
        drain("resync");
        chk("resync_errs", n_err, 3);
        chk("resync_err_byte", popped_byte[last_err_cyc - 1], 'h40);
        chk("resync_loads", n_load, 2);
        chk("resync_digits", int'(dut_digits), 'h235959);

        push("@12", 1);
        for (int k = 0; k < 100 && fifo.size() != 0; k++) step();
        repeat (20) step();
        chk("tmo_errs", n_err, 4);
        chk("tmo_latency", last_err_cyc - last_pop_cyc, 16);
        chk("tmo_last_byte", popped_byte[last_pop_cyc], 'h32);
        chk("tmo_busy", int'(oBusy), 0);
        push("@01:02:03\r", 1);
        drain("post_tmo");
        chk("post_tmo_digits", int'(dut_digits), 'h010203);
        chk("post_tmo_loads", n_load, 3);

        e0 = n_err; l0 = n_load;
        push("@12:", 1);
        for (int k = 0; k < 100 && fifo.size() != 0; k++) step();
        repeat (3) step();
        chk("pre_reset_busy", int'(oBusy), 1);
        iRst = 1'b0;
        fifo.delete();
        drive();
        repeat (3) step();
        chk("rst_digits", int'(dut_digits), 0);
        chk("rst_busy", int'(oBusy), 0);
        iRst = 1'b1;
        repeat (2) step();
        chk("rst_errs", n_err, e0);
        push("@07:08:09\n", 1);
        drain("post_rst");
        chk("post_rst_digits", int'(dut_digits), 'h070809);
        chk("post_rst_loads", n_load, l0 + 1);
        chk("post_rst_errs", n_err, e0);

        for (int f = 0; f < 1000; f++) begin
            string s;
            int h, m, sec, gap;
            s   = "@00:00:00\n";
            h   = $urandom_range(23, 0);
            m   = $urandom_range(59, 0);
            sec = $urandom_range(59, 0);
            s[1] = 8'(8'h30 + h / 10);   s[2] = 8'(8'h30 + h % 10);
            s[4] = 8'(8'h30 + m / 10);   s[5] = 8'(8'h30 + m % 10);
            s[7] = 8'(8'h30 + sec / 10); s[8] = 8'(8'h30 + sec % 10);
            if ($urandom_range(1, 0) == 1) s[9] = 8'h0D;
            if ($urandom_range(7, 0) == 0) s[$urandom_range(9, 0)] = 8'($urandom_range(255, 0));
            gap = ($urandom_range(1, 0) == 1) ? 0 : 3;
            push(s, gap);
            if (f % 8 == 7) drain("random");
        end
        drain("random_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/time_cmd_parser.md
TIME_CMD_PARSER -- requirements
Module: time_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning the inter-byte timeout in iClk cycles (1 s at 100 MHz).
REQ-002 SHALL have port iClk, input, 1 bit: system clock; all logic on the rising edge.
REQ-003 SHALL have port iRst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port iRx_Empty, input, 1 bit: RX FIFO empty flag.
REQ-005 SHALL have port iRx_Data, input, 8 bits: RX FIFO head byte (first-word-fall-through), valid while iRx_Empty=0.
REQ-006 SHALL have port oRx_Pop, output, 1 bit: single-cycle pulse that consumes the head byte.
REQ-007 SHALL have ports oDigit_Hour_10, oDigit_Hour_1, oDigit_Min_10, oDigit_Min_1, oDigit_Sec_10, oDigit_Sec_1, each output, 4 bits: last accepted BCD time.
REQ-008 SHALL have port oLoad, output, 1 bit: single-cycle pulse when new digits become valid.
REQ-009 SHALL have port oErr, output, 1 bit: single-cycle pulse on a rejected frame.
REQ-010 SHALL have port oBusy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL accept this frame: '@'(0x40) H10 H1 ':'(0x3A) M10 M1 ':' S10 S1 TERM. TERM SHALL be 0x0D or 0x0A. Digits SHALL be ASCII '0'-'9'.
REQ-012 FSM states SHALL be IDLE, HR10, HR1, COL1, MIN10, MIN1, COL2, SEC10, SEC1, TERM, LOAD. Each state SHALL advance on one consumed byte, except LOAD.
REQ-013 SHALL assert oRx_Pop for exactly one cycle when iRx_Empty=0 and no pop occurred in the previous cycle. The consumed byte SHALL be the iRx_Data sampled in that pop cycle. Throughput SHALL be at most one byte per 2 cycles.
REQ-014 In IDLE, every non-'@' byte SHALL be consumed and discarded silently, with no oErr. '@' SHALL move the FSM to HR10.
REQ-015 Range rules: H10 SHALL be 0-2. If H10=2, H1 SHALL be 0-3. H1 SHALL otherwise be 0-9. M10 and S10 SHALL be 0-5. M1 and S1 SHALL be 0-9.
REQ-016 Digit shadow registers SHALL capture byte-0x30 (low nibble) in their state. The output digits SHALL change only in LOAD.
REQ-017 A byte violating REQ-011 or REQ-015 in a non-IDLE state SHALL cause a 1-cycle oErr pulse in the following cycle and discard the partial frame. The next state SHALL be HR10 if the offending byte is '@' (resync), else IDLE.
REQ-018 A valid TERM SHALL move the FSM to LOAD. In LOAD, all six outputs SHALL update simultaneously, oLoad SHALL pulse for one cycle, and the FSM SHALL return to IDLE the next cycle.
REQ-019 oLoad latency SHALL be exactly 1 cycle after the pop cycle of TERM.
REQ-020 An inter-byte timeout counter SHALL behave as follows:
- cleared on every pop and in IDLE;
- incremented each cycle in states HR10..TERM;
- on reaching TIMEOUT_CYCLES-1, it SHALL force IDLE and a 1-cycle oErr pulse.
REQ-021 oLoad and oErr SHALL never be high in the same cycle.
REQ-022 If a byte arrives in the same cycle the timeout fires, the timeout SHALL take priority and no pop SHALL occur that cycle.
REQ-023 While iRx_Empty=1, oRx_Pop SHALL stay 0. The FSM and digits SHALL hold, with only the timeout counter advancing.
REQ-024 The counter width SHALL be $clog2(TIMEOUT_CYCLES), with no wrap past terminal count.

Reset
REQ-025 On iRst=0, the block SHALL asynchronously set: FSM to IDLE, all digit outputs and shadows to 0, oLoad/oErr/oRx_Pop/oBusy to 0, and the timeout counter and pop-history flag to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame without an oErr pulse. Normal operation SHALL resume on the first edge after iRst returns to 1.

Verification
REQ-027 Valid frame "@12:34:56\r" → digits 1,2,3,4,5,6 and one oLoad pulse 1 cycle after TERM pop.
REQ-028 Range test "@24:00:00\n", then "@23:60:00\n" → first frame: oErr after byte '4', digits unchanged. Second frame: oErr after byte '6'.
REQ-029 Resync test "@12:3@23:59:59\n" → oErr at the second '@', then digits 2,3,5,9,5,9 and oLoad; the leading garbage "xyz" before any frame SHALL produce no oErr.
REQ-030 Timeout test with TIMEOUT_CYCLES=16: "@12" then the FIFO stays empty for 20 cycles → oErr at cycle 16 after the last pop, oBusy=0. A subsequent full frame SHALL load normally.
REQ-031 Flow control: random iRx_Empty gaps and a back-to-back full FIFO → never two consecutive pop cycles, no byte lost or duplicated. Checked against a reference model over 1000 random frames.
REQ-032 Reset test: iRst low during MIN10 → outputs 0, oErr and oLoad never pulse, FSM in IDLE. A frame sent after release SHALL load correctly.
